// File: rtl/aes_pkg.sv
// Shared AES constants and types for the inverse key schedule: FSM state
// encoding, the round-constant table and the forward S-box.
package aes_pkg;

   // One-hot FSM encoding; any other pattern is treated as corrupted state.
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_EMIT = 4'b0010,
      ST_SUB  = 4'b0100,
      ST_MIX  = 4'b1000
   } state_e;

   localparam int NUM_ROUNDS = 10;

   // Round constants RCON[0..9] (the byte that lands in the top of w0).
   localparam logic [7:0] RCON [NUM_ROUNDS] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   // Forward AES S-box, indexed by the input byte.
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // RotWord: bytes (b0,b1,b2,b3) become (b1,b2,b3,b0), b0 being the MSB.
   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Stepping from round r back to r-1 undoes the expansion step that used
   // RCON[r-1]; rounds outside 1..10 never reach the MIX step.
   function automatic logic [7:0] rcon_for_round(input logic [3:0] round);
      logic [7:0] val;
      val = 8'h00;
      if (round >= 4'd1 && round <= 4'd10) begin
         val = RCON[round - 4'd1];
      end
      return val;
   endfunction

endpackage

// File: rtl/sbox_rom.sv
// Combinational single-byte forward S-box lookup.
module sbox_rom
   import aes_pkg::*;
(
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   // Plain table read; synthesises to a 256x8 ROM / LUT tree.
   always_comb begin
      out_byte = sbox_lookup(in_byte);
   end

endmodule

// File: rtl/inv_key_schedule.sv
// AES-128 inverse key schedule: loads the round-10 key and walks back to the
// round-0 key, presenting each round key on a valid/ready output.
//
// Handshake: rk_out/rk_round are offered while rk_valid=1 and must not change
// until a cycle with rk_valid && rk_ready; that cycle is the transfer. rk_ready
// is ignored whenever rk_valid=0.
module inv_key_schedule
   import aes_pkg::*;
#(
   parameter int SBOX_SHARED = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic         busy,
   output logic         done,
   output logic         o_state_error,
   output logic [3:0]   dbg_state
);

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   byte_cnt_q, byte_cnt_d;
   logic [31:0]  sbytes_q, sbytes_d;
   logic         done_q, done_d;
   logic         state_error_q, state_error_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_t;
   logic [31:0]  sbytes_next;
   logic         sub_last;
   logic [31:0]  p0, p1, p2, p3;

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // w3^w2 is the previous key's w3, whose rotated S-boxed form fed w0.
   assign rot_t = rot_word(w3 ^ w2);

   generate
      if (SBOX_SHARED != 0) begin : g_shared
         logic [7:0] lane_in;
         logic [7:0] lane_out;

         sbox_rom u_sbox (
            .in_byte  (lane_in),
            .out_byte (lane_out)
         );

         // Select the rotated byte addressed by the byte counter, MSB first.
         always_comb begin
            lane_in = rot_t[31:24];
            case (byte_cnt_q)
               2'd0: lane_in = rot_t[31:24];
               2'd1: lane_in = rot_t[23:16];
               2'd2: lane_in = rot_t[15:8];
               default: lane_in = rot_t[7:0];
            endcase
         end

         // Merge the looked-up byte into its lane of the partial S-box word.
         always_comb begin
            sbytes_next = sbytes_q;
            case (byte_cnt_q)
               2'd0: sbytes_next[31:24] = lane_out;
               2'd1: sbytes_next[23:16] = lane_out;
               2'd2: sbytes_next[15:8]  = lane_out;
               default: sbytes_next[7:0] = lane_out;
            endcase
         end

         assign sub_last = (byte_cnt_q == 2'd3);
      end else begin : g_parallel
         for (genvar i = 0; i < 4; i++) begin : g_lane
            sbox_rom u_sbox (
               .in_byte  (rot_t[8*i +: 8]),
               .out_byte (sbytes_next[8*i +: 8])
            );
         end

         assign sub_last = 1'b1;
      end
   endgenerate

   // Previous-round words; p0 removes the S-box/RCON term that built w0.
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   assign p0 = w0 ^ sbytes_q ^ {rcon_for_round(round_q), 24'h000000};

   // Next-state and datapath updates; unknown encodings fall back to IDLE.
   always_comb begin
      state_d       = state_q;
      key_d         = key_q;
      round_d       = round_q;
      byte_cnt_d    = byte_cnt_q;
      sbytes_d      = sbytes_q;
      done_d        = 1'b0;
      state_error_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // The done cycle is still the tail of the previous sequence.
            if (start && !done_q) begin
               key_d      = key_in;
               round_d    = 4'd10;
               byte_cnt_d = 2'd0;
               state_d    = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (rk_ready) begin
               if (round_q == 4'd0) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  byte_cnt_d = 2'd0;
                  state_d    = ST_SUB;
               end
            end
         end
         ST_SUB: begin
            sbytes_d = sbytes_next;
            if (sub_last) begin
               byte_cnt_d = 2'd0;
               state_d    = ST_MIX;
            end else begin
               byte_cnt_d = byte_cnt_q + 2'd1;
            end
         end
         ST_MIX: begin
            key_d   = {p0, p1, p2, p3};
            round_d = round_q - 4'd1;
            state_d = ST_EMIT;
         end
         default: begin
            state_d       = ST_IDLE;
            state_error_d = 1'b1;
         end
      endcase
   end

   // State and datapath registers; reset overrides start and handshakes.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         key_q         <= '0;
         round_q       <= 4'd0;
         byte_cnt_q    <= 2'd0;
         sbytes_q      <= '0;
         done_q        <= 1'b0;
         state_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         round_q       <= round_d;
         byte_cnt_q    <= byte_cnt_d;
         sbytes_q      <= sbytes_d;
         done_q        <= done_d;
         state_error_q <= state_error_d;
      end
   end

   assign rk_out        = key_q;
   assign rk_round      = round_q;
   assign rk_valid      = (state_q == ST_EMIT);
   assign busy          = (state_q != ST_IDLE);
   assign done          = done_q;
   assign o_state_error = state_error_q;
   assign dbg_state     = state_q;

endmodule

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

Interface
REQ-001 The block SHALL have parameter SBOX_SHARED, default 1. 1 = one byte lookup reused over 4 cycles; 0 = four lookups in parallel in 1 cycle.
REQ-002 clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request: load key_in as the round-10 key.
REQ-005 key_in  input  128  round-10 key; word w0 is at [127:96] and w3 is at [31:0].
REQ-006 rk_out  output  128  current round key, same word order as key_in.
REQ-007 rk_round  output  4  round index of rk_out, from 10 down to 0.
REQ-008 rk_valid  output  1  rk_out and rk_round are valid.
REQ-009 rk_ready  input  1  consumer accepts rk_out.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the round-0 key is accepted.
REQ-012 o_state_error  output  1  one-cycle pulse when an illegal FSM encoding is detected.

Function
REQ-013 FSM states SHALL be IDLE, EMIT, SUB and MIX, one-hot encoded.
REQ-014 IDLE: start=1 SHALL load key_in into the key register, set round to 10 and go to EMIT; start=0 SHALL stay in IDLE.
REQ-015 EMIT: rk_valid SHALL be 1, and rk_out/rk_round SHALL hold stable until rk_valid&&rk_ready.
REQ-016 EMIT handshake with round==0: go to IDLE and pulse done in the next cycle.
REQ-017 EMIT handshake with round>0: go to SUB.
REQ-018 SUB: compute t = w3^w2, rotate it left one byte (b1,b2,b3,b0), then S-box each byte.
REQ-019 SUB timing: with SBOX_SHARED=1, one byte per cycle (byte counter 0..3, wraps to 0), then go to MIX; with SBOX_SHARED=0, one cycle, then go to MIX.
REQ-020 MIX SHALL compute the previous key:
 - p3=w3^w2, p2=w2^w1, p1=w1^w0
 - p0=w0^{Sbytes ^ (RCON[round-1]<<24)}
 - then decrement round and go to EMIT.
REQ-021 RCON SHALL be, for index 0..9: 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-022 start to first rk_valid SHALL be 1 cycle.
REQ-023 Accept to next rk_valid SHALL be 5 cycles when SBOX_SHARED=1 and 2 cycles when SBOX_SHARED=0.
REQ-024 rk_ready while rk_valid=0 SHALL be ignored.
REQ-025 start while busy=1 SHALL be ignored, including in the cycle done pulses.
REQ-026 start in the IDLE cycle that follows done SHALL begin a new sequence normally.
REQ-027 An illegal state encoding SHALL force IDLE on the next edge and pulse o_state_error.
REQ-028 Outputs in IDLE: rk_valid=0; rk_out/rk_round hold the last values.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE, key register=0, rk_round=0, byte counter=0, rk_valid=0, busy=0, done=0, o_state_error=0.
REQ-030 reset SHALL take priority over start and over handshakes in the same cycle.
REQ-031 reset mid-sequence SHALL abandon the sequence; no done pulse SHALL follow.

Structure
REQ-032 Package aes_pkg SHALL hold the RCON table, the 256-entry forward S-box table and the FSM state type.
REQ-033 Sub-module sbox_rom SHALL be a combinational 8-bit lookup from aes_pkg, instantiated once (SBOX_SHARED=1) or four times (SBOX_SHARED=0).

Verification
REQ-034 Start with key_in = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 and rk_ready=1:
 - first key shall be round 10 equal to key_in;
 - next key shall be round 9 = ac7766f3 19fadc21 28d12941 575c006e;
 - final key shall be round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c, followed by a done pulse.
REQ-035 Same run with rk_ready toggled randomly: identical key sequence, with rk_out stable whenever rk_valid=1 and rk_ready=0.
REQ-036 With rk_ready=1, measure start-to-done: 1+10*(5+1)=61 cycles (SHARED=1) and 1+10*(2+1)=31 cycles (SHARED=0).
REQ-037 Assert reset while rk_round=5: next cycle busy=0 and rk_valid=0, with no done pulse; a following start shall produce the full correct sequence.
REQ-038 Assert start during SUB: no effect, and the sequence completes unchanged.
REQ-039 Force an illegal state via the bench: o_state_error pulses once and the FSM is in IDLE on the next cycle.
